// File: rtl/exc_pkg.sv
// exc_pkg: exception codes, vector offsets, flag/select indices and FSM state for exception_ctrl
package exc_pkg;
  localparam logic [4:0] EX_INT  = 5'd0;
  localparam logic [4:0] EX_MOD  = 5'd1;
  localparam logic [4:0] EX_TLBL = 5'd2;
  localparam logic [4:0] EX_TLBS = 5'd3;
  localparam logic [4:0] EX_ADEL = 5'd4;
  localparam logic [4:0] EX_ADES = 5'd5;
  localparam logic [4:0] EX_SYS  = 5'd8;
  localparam logic [4:0] EX_BP   = 5'd9;
  localparam logic [4:0] EX_RI   = 5'd10;
  localparam logic [4:0] EX_OV   = 5'd12;
  localparam logic [31:0] OFF_REFILL = 32'h0000_0000;
  localparam logic [31:0] OFF_GEN    = 32'h0000_0180;
  localparam logic [31:0] OFF_IV     = 32'h0000_0200;
  localparam int F_MOD = 1;
  // select indices 1..11 coincide with the exc_flags bit positions
  localparam int S_INT  = 0;
  localparam int S_MOD  = 1;
  localparam int S_IREF = 2;
  localparam int S_DREF = 3;
  localparam int S_IINV = 4;
  localparam int S_DINV = 5;
  localparam int S_IADE = 6;
  localparam int S_DADE = 7;
  localparam int S_SYS  = 8;
  localparam int S_BP   = 9;
  localparam int S_RI   = 10;
  localparam int S_OV   = 11;
  localparam int S_ERET = 12;
  localparam int NSEL   = 13;
  localparam logic [NSEL-1:0] I_MASK = 13'h0054;
  localparam logic [NSEL-1:0] D_MASK = 13'h00AA;
  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_HOLD} state_e;
  typedef enum logic [1:0] {BVA_NONE, BVA_PC, BVA_DATA} bva_src_e;
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: picks the highest-priority pending exception/ERET as a one-hot select with its ExcCode
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic [11:0]     exc_flags,
  input  logic            data_we,
  input  logic            int_req,
  input  logic            eret,
  output logic [NSEL-1:0] sel,
  output logic [4:0]      exp_code,
  output bva_src_e        bva_src
);
  logic [NSEL-1:0] req;
  logic            unused_flag;
  assign unused_flag = exc_flags[0];
  assign req = {eret, exc_flags[11:2], exc_flags[F_MOD] & data_we, int_req};
  // lowest set bit is the highest priority
  assign sel = req & (~req + NSEL'(1));
  always_comb begin
    exp_code = sel[S_INT]                 ? EX_INT
             : sel[S_MOD]                 ? EX_MOD
             : (sel[S_DREF] | sel[S_DINV]) ? (data_we ? EX_TLBS : EX_TLBL)
             : (sel[S_IREF] | sel[S_IINV]) ? EX_TLBL
             : sel[S_IADE]                ? EX_ADEL
             : sel[S_DADE]                ? (data_we ? EX_ADES : EX_ADEL)
             : sel[S_SYS]                 ? EX_SYS
             : sel[S_BP]                  ? EX_BP
             : sel[S_RI]                  ? EX_RI
             : sel[S_OV]                  ? EX_OV
             : EX_INT;
    bva_src  = |(sel & I_MASK) ? BVA_PC : |(sel & D_MASK) ? BVA_DATA : BVA_NONE;
  end
endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: commit-stage exception/ERET controller producing CP0 strobes, redirect PC and held flush
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int          NUM_INT     = 8,
  parameter logic [31:0] BEV_BASE    = 32'hBFC0_0200,
  parameter bit          SUPPORT_IV  = 1'b1,
  parameter bit          SUPPORT_EXL = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               commit_valid,
  input  logic [31:0]        pc,
  input  logic [31:0]        data_vaddr,
  input  logic               data_we,
  input  logic               in_delayslot,
  input  logic [11:0]        exc_flags,
  input  logic               eret,
  input  logic [31:0]        epc_in,
  input  logic               status_ie,
  input  logic               status_exl,
  input  logic               status_bev,
  input  logic               cause_iv,
  input  logic [31:0]        ebase,
  input  logic [NUM_INT-1:0] int_pending,
  input  logic [NUM_INT-1:0] int_mask,
  input  logic               fetch_busy,
  input  logic               fetch_data_ok,
  output logic               exc_now,
  output logic               flush,
  output logic [31:0]        redirect_pc,
  output logic               wr_exp,
  output logic [4:0]         exp_code,
  output logic               epc_we,
  output logic [31:0]        epc,
  output logic               bd,
  output logic               badvaddr_we,
  output logic [31:0]        badvaddr,
  output logic               clear_exl
);
  state_e          state, state_nx;
  logic [NSEL-1:0] sel;
  logic [4:0]      code;
  bva_src_e        bva_src;
  logic            int_req, settle, refill, is_eret, exl_block;
  logic [31:0]     base, offset, vec;
  logic [11:0]     unused_ebase;
  assign unused_ebase = ebase[11:0];
  assign int_req = status_ie & ~status_exl & |(int_pending & int_mask);
  exc_prio_enc u_enc (
    .exc_flags(exc_flags),
    .data_we  (data_we),
    .int_req  (int_req),
    .eret     (eret),
    .sel      (sel),
    .exp_code (code),
    .bva_src  (bva_src)
  );
  assign exl_block = SUPPORT_EXL & status_exl;
  assign is_eret   = sel[S_ERET];
  assign refill    = sel[S_IREF] | sel[S_DREF];
  // FLUSH that settles this cycle may accept a new exception; HOLD never does
  always_comb begin
    settle   = ~fetch_busy | fetch_data_ok;
    exc_now  = commit_valid & (|sel) & ((state == ST_IDLE) | ((state == ST_FLUSH) & settle));
    base     = status_bev ? BEV_BASE : {ebase[31:12], 12'h000};
    offset   = (refill & ~exl_block) ? OFF_REFILL
             : (sel[S_INT] & cause_iv & SUPPORT_IV) ? OFF_IV : OFF_GEN;
    vec      = is_eret ? epc_in : base + offset;
    state_nx = exc_now ? ST_FLUSH
             : (state == ST_FLUSH) ? (settle ? ST_IDLE : ST_HOLD)
             : (state == ST_HOLD) ? (fetch_data_ok ? ST_IDLE : ST_HOLD)
             : ST_IDLE;
  end
  assign flush = state != ST_IDLE;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      redirect_pc <= '0;
      wr_exp      <= 1'b0;
      exp_code    <= '0;
      epc_we      <= 1'b0;
      epc         <= '0;
      bd          <= 1'b0;
      badvaddr_we <= 1'b0;
      badvaddr    <= '0;
      clear_exl   <= 1'b0;
    end else begin
      state       <= state_nx;
      wr_exp      <= exc_now & ~is_eret;
      epc_we      <= exc_now & ~is_eret & ~exl_block;
      clear_exl   <= exc_now & is_eret;
      badvaddr_we <= exc_now & (bva_src != BVA_NONE);
      if (exc_now) begin
        redirect_pc <= vec;
        exp_code    <= code;
        epc         <= in_delayslot ? pc - 32'd4 : pc;
        bd          <= in_delayslot;
        badvaddr    <= bva_src == BVA_PC ? pc : bva_src == BVA_DATA ? data_vaddr : 32'h0;
      end
    end
  end
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed vectors with a scoreboard queue checked by a strobe-driven monitor
module tb_exception_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        commit_valid, data_we, in_delayslot, eret;
  logic        status_ie, status_exl, status_bev, cause_iv, fetch_busy, fetch_data_ok;
  logic [31:0] pc, data_vaddr, epc_in, ebase;
  logic [11:0] exc_flags;
  logic [7:0]  int_pending, int_mask;
  logic        exc_now, flush, wr_exp, epc_we, bd, badvaddr_we, clear_exl;
  logic [31:0] redirect_pc, epc, badvaddr;
  logic [4:0]  exp_code;

  typedef struct {
    logic        wr, ew, cl, bd, bw;
    logic [4:0]  code;
    logic [31:0] epc, bva, rd;
  } exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exception_ctrl #(.NUM_INT(8)) dut (
    .clk(clk), .resetn(resetn), .commit_valid(commit_valid), .pc(pc),
    .data_vaddr(data_vaddr), .data_we(data_we), .in_delayslot(in_delayslot),
    .exc_flags(exc_flags), .eret(eret), .epc_in(epc_in), .status_ie(status_ie),
    .status_exl(status_exl), .status_bev(status_bev), .cause_iv(cause_iv),
    .ebase(ebase), .int_pending(int_pending), .int_mask(int_mask),
    .fetch_busy(fetch_busy), .fetch_data_ok(fetch_data_ok), .exc_now(exc_now),
    .flush(flush), .redirect_pc(redirect_pc), .wr_exp(wr_exp), .exp_code(exp_code),
    .epc_we(epc_we), .epc(epc), .bd(bd), .badvaddr_we(badvaddr_we),
    .badvaddr(badvaddr), .clear_exl(clear_exl)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic wr, ew, cl, b, bw, input logic [4:0] code,
                              input logic [31:0] e, bva, rd);
    exp_t x;
    x.wr = wr; x.ew = ew; x.cl = cl; x.bd = b; x.bw = bw;
    x.code = code; x.epc = e; x.bva = bva; x.rd = rd;
    return x;
  endfunction

  always @(negedge clk) begin
    if (resetn && (wr_exp || clear_exl)) begin
      exp_t e;
      if (q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("wr_exp", wr_exp, e.wr);
        chk("epc_we", epc_we, e.ew);
        chk("clear_exl", clear_exl, e.cl);
        chk("bd", bd, e.bd);
        chk("badvaddr_we", badvaddr_we, e.bw);
        chk("exp_code", exp_code, e.code);
        chk("epc", epc, e.epc);
        chk("badvaddr", badvaddr, e.bva);
        chk("redirect_pc", redirect_pc, e.rd);
      end
    end
  end

  task automatic clr();
    commit_valid = 0; exc_flags = '0; eret = 0; data_we = 0; in_delayslot = 0;
    int_pending = '0; int_mask = '0; status_ie = 0; status_exl = 0; status_bev = 1;
    cause_iv = 0; ebase = '0; pc = '0; data_vaddr = '0; epc_in = '0;
    fetch_busy = 0; fetch_data_ok = 0;
  endtask

  task automatic issue(input exp_t e);
    q.push_back(e);
    commit_valid = 1;
    #1 chk("exc_now", exc_now, 1);
    @(posedge clk);
    #1 commit_valid = 0;
    chk("flush_set", flush, 1);
  endtask

  task automatic settle_wait();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!flush) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("flush_timeout", flush, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic go(input exp_t e);
    issue(e);
    settle_wait();
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_strobes", {wr_exp, epc_we, clear_exl, badvaddr_we}, 0);
    chk("rst_code", exp_code, 0);
    chk("rst_epc", epc, 0);
    resetn = 1;
    @(posedge clk);
    #1;
    int_pending = 8'h04; int_mask = 8'hFB; status_ie = 1; commit_valid = 1;
    #1 chk("masked_int_no_take", exc_now, 0);
    clr(); exc_flags = 12'h800;
    #1 chk("bubble_no_take", exc_now, 0);
    clr(); int_pending = 8'h04; int_mask = 8'hFF; status_ie = 1; status_exl = 1; commit_valid = 1;
    #1 chk("exl_blocks_int", exc_now, 0);
    clr();
    @(posedge clk);
    #1;
    clr(); int_pending = 8'h04; int_mask = 8'hFF; status_ie = 1; pc = 32'h8000_1000;
    go(mk(1, 1, 0, 0, 0, 5'd0, 32'h8000_1000, 32'h0, 32'hBFC0_0380));
    clr(); exc_flags = 12'h008; data_we = 1; status_bev = 0; ebase = 32'h8000_0000;
    data_vaddr = 32'h0040_0004; pc = 32'h8000_2000;
    go(mk(1, 1, 0, 0, 1, 5'd3, 32'h8000_2000, 32'h0040_0004, 32'h8000_0000));
    clr(); exc_flags = 12'h008; data_we = 1; status_bev = 0; ebase = 32'h8000_0000;
    data_vaddr = 32'h0040_0004; pc = 32'h8000_2000; status_exl = 1;
    go(mk(1, 0, 0, 0, 1, 5'd3, 32'h8000_2000, 32'h0040_0004, 32'h8000_0180));
    clr(); exc_flags = 12'h900; in_delayslot = 1; pc = 32'h0000_1004;
    go(mk(1, 1, 0, 1, 0, 5'd8, 32'h0000_1000, 32'h0, 32'hBFC0_0380));
    clr(); int_pending = 8'h01; int_mask = 8'h01; status_ie = 1; cause_iv = 1;
    status_bev = 0; ebase = 32'h8000_0ABC; pc = 32'h100;
    go(mk(1, 1, 0, 0, 0, 5'd0, 32'h100, 32'h0, 32'h8000_0200));
    clr(); exc_flags = 12'h00E; pc = 32'h600; data_vaddr = 32'h700;
    go(mk(1, 1, 0, 0, 1, 5'd2, 32'h600, 32'h600, 32'hBFC0_0200));
    clr(); exc_flags = 12'h042; data_we = 1; pc = 32'h800; data_vaddr = 32'h900;
    go(mk(1, 1, 0, 0, 1, 5'd1, 32'h800, 32'h900, 32'hBFC0_0380));
    clr(); exc_flags = 12'h080; data_we = 1; pc = 32'hA00; data_vaddr = 32'hA01;
    go(mk(1, 1, 0, 0, 1, 5'd5, 32'hA00, 32'hA01, 32'hBFC0_0380));
    clr(); exc_flags = 12'h020; pc = 32'hB04; data_vaddr = 32'hB00;
    go(mk(1, 1, 0, 0, 1, 5'd2, 32'hB04, 32'hB00, 32'hBFC0_0380));
    clr(); exc_flags = 12'h040; pc = 32'hC02;
    go(mk(1, 1, 0, 0, 1, 5'd4, 32'hC02, 32'hC02, 32'hBFC0_0380));
    clr(); int_pending = 8'h80; int_mask = 8'h80; status_ie = 1; exc_flags = 12'h800; pc = 32'hD00;
    go(mk(1, 1, 0, 0, 0, 5'd0, 32'hD00, 32'h0, 32'hBFC0_0380));
    clr(); exc_flags = 12'h200; in_delayslot = 1; pc = 32'h0;
    go(mk(1, 1, 0, 1, 0, 5'd9, 32'hFFFF_FFFC, 32'h0, 32'hBFC0_0380));
    clr(); exc_flags = 12'h400; pc = 32'hE00;
    go(mk(1, 1, 0, 0, 0, 5'd10, 32'hE00, 32'h0, 32'hBFC0_0380));
    clr(); exc_flags = 12'h800; pc = 32'hE04;
    go(mk(1, 1, 0, 0, 0, 5'd12, 32'hE04, 32'h0, 32'hBFC0_0380));
    clr(); eret = 1; epc_in = 32'hBFC0_0100; pc = 32'h2000; fetch_busy = 1;
    issue(mk(0, 0, 1, 0, 0, 5'd0, 32'h2000, 32'h0, 32'hBFC0_0100));
    commit_valid = 1;
    #1 chk("flush_busy_no_take", exc_now, 0);
    commit_valid = 0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_flush", flush, 1);
      chk("hold_redirect", redirect_pc, 32'hBFC0_0100);
    end
    @(posedge clk);
    #1 fetch_data_ok = 1;
    @(posedge clk);
    #1 fetch_data_ok = 0; fetch_busy = 0;
    chk("hold_release", flush, 0);
    clr(); exc_flags = 12'h100; pc = 32'h3000; fetch_busy = 1;
    issue(mk(1, 1, 0, 0, 0, 5'd8, 32'h3000, 32'h0, 32'hBFC0_0380));
    @(negedge clk);
    chk("pre_rst_flush", flush, 1);
    @(negedge clk);
    #2 resetn = 0;
    #1 chk("rst_hold_flush", flush, 0);
    chk("rst_hold_redirect", redirect_pc, 0);
    @(negedge clk);
    resetn = 1;
    clr();
    @(posedge clk);
    #1;
    int_pending = 8'h04; int_mask = 8'hFF; status_ie = 1; pc = 32'h8000_1000;
    go(mk(1, 1, 0, 0, 0, 5'd0, 32'h8000_1000, 32'h0, 32'hBFC0_0380));
    clr(); exc_flags = 12'h200; pc = 32'h4000;
    q.push_back(mk(1, 1, 0, 0, 0, 5'd9, 32'h4000, 32'h0, 32'hBFC0_0380));
    commit_valid = 1;
    @(posedge clk);
    #1 exc_flags = 12'h400; pc = 32'h5000; status_bev = 0; ebase = 32'h8000_0000;
    q.push_back(mk(1, 1, 0, 0, 0, 5'd10, 32'h5000, 32'h0, 32'h8000_0180));
    #1 chk("retake_in_flush", exc_now, 1);
    @(posedge clk);
    #1 commit_valid = 0;
    chk("retake_flush", flush, 1);
    chk("retake_redirect", redirect_pc, 32'h8000_0180);
    settle_wait();
    repeat (3) @(posedge clk);
    #1 chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
